// File: rtl/tw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tw_pkg                                                     |
// | Description : Shared constants, FSM state encoding and the cosine-table  |
// |               constant function for the twiddle sequence generator.      |
// | Contents    : C_MAX_LOG2N / C_N_MAX / C_QTR / C_ROM_AW defaults,         |
// |               tw_state_e, tw_rom_aw(), tw_qtr(), tw_cos_const()          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tw_pkg;

    // Defaults for the largest supported transform (N_MAX = 8192).
    localparam int C_MAX_LOG2N = 13;
    localparam int C_N_MAX     = 1 << C_MAX_LOG2N;
    localparam int C_QTR       = C_N_MAX / 4;
    localparam int C_ROM_AW    = C_MAX_LOG2N - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tw_state_e;

    // Address width needed to reach entries 0..N_MAX/4 inclusive.
    function automatic int tw_rom_aw(input int max_log2n);
        return max_log2n - 1;
    endfunction

    function automatic int tw_qtr(input int max_log2n);
        return (1 << max_log2n) / 4;
    endfunction

    // round(cos(2*pi*a/N_MAX) * 2^frac_bits); only evaluated at elaboration.
    function automatic int tw_cos_const(input int a, input int max_log2n,
                                        input int frac_bits);
        real ang;
        real val;
        ang = 2.0 * 3.14159265358979323846 * real'(a) / real'(1 << max_log2n);
        val = $cos(ang) * real'(1 << frac_bits);
        if (val >= 0.0) begin
            return $rtoi(val + 0.5);
        end
        return -$rtoi(-val + 0.5);
    endfunction

endpackage : tw_pkg
`default_nettype wire

// File: rtl/tw_quarter_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tw_quarter_rom                                             |
// | Description : Quarter-wave cosine table, N_MAX/4+1 entries, two          |
// |               synchronous read ports with one-cycle latency. Contents    |
// |               are fixed at elaboration from tw_cos_const().              |
// | Ports       : clk, rst      - clock / async active-high reset            |
// |               i_en          - read enable (pipeline advance)             |
// |               i_addr_a/b    - table addresses (0..N_MAX/4)               |
// |               o_data_a/b    - signed table values, registered            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tw_quarter_rom
    import tw_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    parameter int MAX_LOG2N  = C_MAX_LOG2N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic [MAX_LOG2N-2:0]         i_addr_a,
    input  logic [MAX_LOG2N-2:0]         i_addr_b,
    output logic signed [DATA_WIDTH-1:0] o_data_a,
    output logic signed [DATA_WIDTH-1:0] o_data_b
);

    localparam int c_qtr = tw_qtr(MAX_LOG2N);

    logic signed [DATA_WIDTH-1:0] w_rom [0:c_qtr];

    for (genvar a = 0; a <= c_qtr; a++) begin : g_rom
        assign w_rom[a] = DATA_WIDTH'(tw_cos_const(a, MAX_LOG2N, FRAC_BITS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data_a <= '0;
            o_data_b <= '0;
        end else if (i_en) begin
            o_data_a <= w_rom[i_addr_a];
            o_data_b <= w_rom[i_addr_b];
        end
    end

endmodule : tw_quarter_rom
`default_nettype wire

// File: rtl/tw_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tw_seq_gen                                                 |
// | Description : Streams the twiddle factors for one radix-2 DIT stage of   |
// |               an N = 2^log2n point FFT (forward or conjugate) through a  |
// |               3-stage stallable valid/ready pipeline.                    |
// | Ports       : clk, rst          - clock / async active-high reset        |
// |               start             - command strobe (IDLE only)             |
// |               log2n, stage      - size select and DIT stage             |
// |               inverse           - 1 = conjugate output                  |
// |               busy, cfg_err     - status / illegal-command pulse         |
// |               w_valid,out_ready - output handshake                       |
// |               w                 - {re, im}, re in upper half             |
// |               k_out             - table index scaled to N_MAX            |
// |               w_last, done      - final beat marker / completion pulse   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tw_seq_gen
    import tw_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    parameter int MAX_LOG2N  = C_MAX_LOG2N,
    parameter int LOG2N_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LOG2N_W-1:0]      log2n,
    input  logic [LOG2N_W-1:0]      stage,
    input  logic                    inverse,
    output logic                    busy,
    output logic                    cfg_err,
    output logic                    w_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] w,
    output logic [MAX_LOG2N-1:0]    k_out,
    output logic                    w_last,
    output logic                    done
);

    localparam int c_jw = MAX_LOG2N - 1;   // j spans 0..N_MAX/2-1
    localparam int c_aw = MAX_LOG2N - 1;   // ROM address, reaches N_MAX/4
    localparam int c_rw = MAX_LOG2N - 2;   // offset inside a quadrant
    localparam logic [c_aw-1:0] c_qtr_addr = c_aw'(1 << c_rw);

    // Elaboration guards
    if (FRAC_BITS > DATA_WIDTH - 2) begin : g_chk_frac
        $error("tw_seq_gen: FRAC_BITS must not exceed DATA_WIDTH-2");
    end
    if (MAX_LOG2N < 3) begin : g_chk_max
        $error("tw_seq_gen: MAX_LOG2N must be at least 3");
    end
    if ((1 << LOG2N_W) <= MAX_LOG2N) begin : g_chk_lw
        $error("tw_seq_gen: LOG2N_W too narrow for MAX_LOG2N");
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    tw_state_e           r_state;
    tw_state_e           w_state_nxt;
    logic [LOG2N_W-1:0]  r_log2n;
    logic [LOG2N_W-1:0]  r_stage;
    logic                r_inverse;
    logic [c_jw-1:0]     r_j;
    logic                r_cfg_err;
    logic                r_done;

    logic                w_en;
    logic                w_cfg_ok;
    logic                w_accept;
    logic                w_issue;
    logic                w_cfg_bad;
    logic                w_done_nxt;
    logic                w_j_last;
    logic                w_final_hs;
    logic [c_jw-1:0]     w_jmax;

    // One global enable: a held output beat freezes every stage behind it.
    assign w_en       = !w_valid || out_ready;
    assign w_cfg_ok   = (int'(log2n) >= 2) && (int'(log2n) <= MAX_LOG2N) &&
                        (stage < log2n);
    // For log2n = MAX_LOG2N the shift wraps to 0 and the -1 yields all ones.
    assign w_jmax     = (c_jw'(1) << (r_log2n - LOG2N_W'(1))) - c_jw'(1);
    assign w_j_last   = (r_j == w_jmax);
    assign w_final_hs = w_valid && out_ready && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_cfg_bad   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_cfg_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_en) begin
                    w_issue = 1'b1;
                    if (w_j_last) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_final_hs) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_log2n   <= '0;
            r_stage   <= '0;
            r_inverse <= 1'b0;
            r_j       <= '0;
            r_cfg_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_bad;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_log2n   <= log2n;
                r_stage   <= stage;
                r_inverse <= inverse;
                r_j       <= '0;
            end else if (w_issue) begin
                r_j <= r_j + c_jw'(1);
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign cfg_err = r_cfg_err;
    assign done    = r_done;

    // ------------------------------------------------------------------
    // Stage 1: index generation
    // k_out = (j mod 2^s) << (log2n-1-s) << (MAX-log2n)
    //       = (j mod 2^s) << (MAX-1-s); log2n only sets the stream length.
    // ------------------------------------------------------------------
    logic [MAX_LOG2N-1:0] w_mask;
    logic [LOG2N_W-1:0]   w_shamt;
    logic [MAX_LOG2N-1:0] w_k;
    logic                 r1_valid;
    logic [MAX_LOG2N-1:0] r1_k;
    logic                 r1_last;

    assign w_mask  = (MAX_LOG2N'(1) << r_stage) - MAX_LOG2N'(1);
    assign w_shamt = LOG2N_W'(MAX_LOG2N - 1) - r_stage;
    assign w_k     = (MAX_LOG2N'(r_j) & w_mask) << w_shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_k     <= '0;
            r1_last  <= 1'b0;
        end else if (w_en) begin
            r1_valid <= w_issue;
            r1_k     <= w_k;
            r1_last  <= w_issue && w_j_last;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: ROM read of C[r] and C[Q-r]
    // ------------------------------------------------------------------
    logic [c_aw-1:0]              w_addr_a;
    logic [c_aw-1:0]              w_addr_b;
    logic signed [DATA_WIDTH-1:0] w_ca;
    logic signed [DATA_WIDTH-1:0] w_cb;
    logic                         r2_valid;
    logic [MAX_LOG2N-1:0]         r2_k;
    logic                         r2_last;

    assign w_addr_a = {1'b0, r1_k[c_rw-1:0]};
    assign w_addr_b = c_qtr_addr - w_addr_a;

    tw_quarter_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .MAX_LOG2N  (MAX_LOG2N)
    ) u_rom (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_en),
        .i_addr_a (w_addr_a),
        .i_addr_b (w_addr_b),
        .o_data_a (w_ca),
        .o_data_b (w_cb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_k     <= '0;
            r2_last  <= 1'b0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_k     <= r1_k;
            r2_last  <= r1_last;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: quadrant sign/swap, optional conjugate, output register
    // ------------------------------------------------------------------
    logic [1:0]                   w_q;
    logic signed [DATA_WIDTH-1:0] w_re;
    logic signed [DATA_WIDTH-1:0] w_im;
    logic                         r_w_valid;
    logic [2*DATA_WIDTH-1:0]      r_w;
    logic [MAX_LOG2N-1:0]         r_k_out;
    logic                         r_w_last;

    assign w_q = r2_k[MAX_LOG2N-1:MAX_LOG2N-2];

    always_comb begin
        w_re = w_ca;
        w_im = -w_cb;
        case (w_q)
            2'd0: begin
                w_re = w_ca;
                w_im = -w_cb;
            end
            2'd1: begin
                w_re = -w_cb;
                w_im = -w_ca;
            end
            2'd2: begin
                w_re = -w_ca;
                w_im = w_cb;
            end
            default: begin
                w_re = w_cb;
                w_im = w_ca;
            end
        endcase
        // |C| <= 2^FRAC_BITS, so this negation never overflows.
        if (r_inverse) begin
            w_im = -w_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_valid <= 1'b0;
            r_w       <= '0;
            r_k_out   <= '0;
            r_w_last  <= 1'b0;
        end else if (w_en) begin
            r_w_valid <= r2_valid;
            r_w       <= {w_re, w_im};
            r_k_out   <= r2_k;
            r_w_last  <= r2_last;
        end
    end

    assign w_valid = r_w_valid;
    assign w       = r_w;
    assign k_out   = r_k_out;
    assign w_last  = r_w_last;

endmodule : tw_seq_gen
`default_nettype wire

// File: tb/tb_tw_seq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tw_seq_gen                                              |
// | Description : Self-checking bench for tw_seq_gen. Expected beats are     |
// |               queued when a command is issued and popped on handshake.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tw_seq_gen;

    localparam int DW = 16;
    localparam int FB = 14;
    localparam int ML = 13;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] log2n;
    logic [LW-1:0] stage;
    logic          inverse;
    logic          busy;
    logic          cfg_err;
    logic          w_valid;
    logic          out_ready;
    logic [2*DW-1:0] w;
    logic [ML-1:0] k_out;
    logic          w_last;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int k;
        int re;
        int im;
        bit last;
        int tol;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    tw_seq_gen #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .MAX_LOG2N  (ML),
        .LOG2N_W    (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .log2n     (log2n),
        .stage     (stage),
        .inverse   (inverse),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .w_valid   (w_valid),
        .out_ready (out_ready),
        .w         (w),
        .k_out     (k_out),
        .w_last    (w_last),
        .done      (done)
    );

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: W = e^{-j 2 pi k / N}, directly from cos/sin.
    task automatic push_model(input int l, input int s, input bit inv);
        int  n;
        int  k;
        int  kt;
        real ang;
        exp_t e;
        n = 1 << l;
        for (int j = 0; j < n / 2; j++) begin
            k   = (j % (1 << s)) << (l - 1 - s);
            kt  = k << (ML - l);
            ang = 2.0 * 3.14159265358979323846 * real'(kt) / real'(1 << ML);
            e.k    = kt;
            e.re   = rnd($cos(ang) * real'(1 << FB));
            e.im   = -rnd($sin(ang) * real'(1 << FB));
            if (inv) e.im = -e.im;
            e.last = (j == n / 2 - 1);
            e.tol  = 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_exact(input int k, input int re, input int im, input bit last);
        exp_t e;
        e.k = k; e.re = re; e.im = im; e.last = last; e.tol = 0;
        exp_q.push_back(e);
    endtask

    task automatic issue_start(input int l, input int s, input bit inv);
        @(negedge clk);
        log2n   = LW'(l);
        stage   = LW'(s);
        inverse = inv;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Runs from the negedge right after the start edge. mode: 0 ready high,
    // 1 fixed toggle pattern, 2 random. stop_after > 0 exits after that many
    // handshakes; inject_at >= 0 pulses a (to be ignored) start there.
    task automatic collect(input int mode, input int stop_after, input int inject_at,
                           input int budget, output int first_valid, output int n_done);
        int          i;
        int          got;
        int          re;
        int          im;
        bit          prev_stall;
        bit          done_due;
        bit          finished;
        logic [2*DW-1:0] h_w;
        logic [ML-1:0]   h_k;
        logic        h_l;
        logic [11:0] pat;
        exp_t        e;
        i = 0; got = 0; prev_stall = 0; done_due = 0; finished = 0;
        h_w = '0; h_k = '0; h_l = 1'b0;
        pat = 12'b1001_0110_1001;
        first_valid = -1;
        n_done = 0;
        while (!finished) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[11 - (i % 12)];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (i == inject_at) begin
                start = 1'b1; log2n = LW'(2); stage = LW'(0); inverse = ~inverse;
            end else begin
                start = 1'b0;
            end
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_start: got %b, want 1", busy);
                end
            end
            if (w_valid === 1'b1 && first_valid < 0) first_valid = i;
            if (prev_stall) begin
                checks++;
                if (w_valid !== 1'b1 || w !== h_w || k_out !== h_k || w_last !== h_l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b w=%h k=%0d last=%b, want v=1 w=%h k=%0d last=%b",
                             w_valid, w, k_out, w_last, h_w, h_k, h_l);
                end
            end
            if (done === 1'b1) n_done++;
            if (done_due) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: got done=%b busy=%b, want done=1 busy=0", done, busy);
                end
                finished = 1;
            end else if (w_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got k_out=%0d, want no beat", k_out);
                end else begin
                    e  = exp_q.pop_front();
                    re = $signed(w[2*DW-1:DW]);
                    im = $signed(w[DW-1:0]);
                    if (int'(k_out) != e.k || w_last !== e.last ||
                        iabs(re - e.re) > e.tol || iabs(im - e.im) > e.tol) begin
                        errors++;
                        $display("FAIL beat%0d: got k=%0d re=%0d im=%0d last=%b, want k=%0d re=%0d im=%0d last=%b",
                                 got, k_out, re, im, w_last, e.k, e.re, e.im, e.last);
                    end
                end
                got++;
                if (w_last === 1'b1) done_due = 1;
                if (stop_after > 0 && got == stop_after) finished = 1;
            end
            prev_stall = (w_valid === 1'b1) && !out_ready;
            h_w = w; h_k = k_out; h_l = w_last;
            i++;
            if (!finished && i > budget) begin
                checks++;
                errors++;
                $display("FAIL timeout: got %0d beats after %0d cycles, want stream end", got, budget);
                finished = 1;
            end
            if (!finished) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, cfg_err, w_valid, w_last, done} !== 5'b0 || w !== '0 || k_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b err=%b v=%b last=%b done=%b w=%h k=%0d, want all 0",
                     busy, cfg_err, w_valid, w_last, done, w, k_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b v=%b, want 0 0", busy, w_valid);
        end
    endtask

    task automatic check_end(input string name, input int fv, input int want_fv, input int nd);
        checks++;
        if ((want_fv >= 0 && fv != want_fv) || nd != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end: got first_valid=%0d dones=%0d left=%0d, want first_valid=%0d dones=1 left=0",
                     name, fv, nd, exp_q.size(), want_fv);
        end
        exp_q.delete();
    endtask

    task automatic test_forward;
        int fv, nd;
        push_exact(0,     16384,      0, 1'b0);
        push_exact(1024,  11585, -11585, 1'b0);
        push_exact(2048,      0, -16384, 1'b0);
        push_exact(3072, -11585, -11585, 1'b1);
        issue_start(3, 2, 1'b0);
        collect(0, 0, -1, 50, fv, nd);
        check_end("forward", fv, 3, nd);
    endtask

    task automatic test_inverse;
        int fv, nd;
        push_exact(0,     16384,      0, 1'b0);
        push_exact(1024,  11585,  11585, 1'b0);
        push_exact(2048,      0,  16384, 1'b0);
        push_exact(3072, -11585,  11585, 1'b1);
        issue_start(3, 2, 1'b1);
        collect(0, 0, -1, 50, fv, nd);
        check_end("inverse", fv, 3, nd);
    endtask

    task automatic test_stage0;
        int fv, nd;
        for (int j = 0; j < 4; j++) push_exact(0, 16384, 0, j == 3);
        issue_start(3, 0, 1'b0);
        collect(0, 0, -1, 50, fv, nd);
        check_end("stage0", fv, 3, nd);
    endtask

    task automatic test_min_size;
        int fv, nd;
        push_model(2, 1, 1'b0);
        issue_start(2, 1, 1'b0);
        collect(0, 0, -1, 50, fv, nd);
        check_end("min_size", fv, 3, nd);
    endtask

    task automatic test_stall;
        int fv, nd;
        push_model(3, 2, 1'b0);
        issue_start(3, 2, 1'b0);
        collect(1, 0, -1, 80, fv, nd);
        check_end("stall", fv, -1, nd);
    endtask

    task automatic test_back_to_back;
        int fv, nd;
        push_model(5, 3, 1'b1);
        issue_start(5, 3, 1'b1);
        collect(2, 0, 4, 200, fv, nd);
        check_end("busy_start", fv, -1, nd);
        push_model(4, 2, 1'b0);
        issue_start(4, 2, 1'b0);
        collect(0, 0, -1, 80, fv, nd);
        check_end("back_to_back", fv, 3, nd);
    endtask

    task automatic test_full_sweep;
        int fv, nd;
        push_model(13, 12, 1'b0);
        issue_start(13, 12, 1'b0);
        collect(0, 0, -1, 4200, fv, nd);
        check_end("sweep", fv, 3, nd);
    endtask

    task automatic test_cfg_err;
        int bad_l[3] = '{1, 3, 14};
        int bad_s[3] = '{0, 3, 0};
        bit seen_v;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            log2n = LW'(bad_l[c]); stage = LW'(bad_s[c]); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse%0d: got err=%b busy=%b, want 1 0", c, cfg_err, busy);
            end
            seen_v = 0;
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                if (w_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) seen_v = 1;
            end
            checks++;
            if (seen_v) begin
                errors++;
                $display("FAIL cfg_err_quiet%0d: got activity after rejected start, want none", c);
            end
        end
    endtask

    task automatic test_reset_mid;
        int fv, nd;
        push_model(3, 2, 1'b0);
        issue_start(3, 2, 1'b0);
        collect(0, 2, -1, 50, fv, nd);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, cfg_err, w_valid, w_last, done} !== 5'b0 || w !== '0 || k_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b v=%b last=%b done=%b w=%h k=%0d, want all 0",
                     busy, w_valid, w_last, done, w, k_out);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_model(3, 1, 1'b1);
        issue_start(3, 1, 1'b1);
        collect(0, 0, -1, 50, fv, nd);
        check_end("after_reset", fv, 3, nd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        log2n     = LW'(3);
        stage     = LW'(2);
        inverse   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_forward();
        test_inverse();
        test_stage0();
        test_min_size();
        test_stall();
        test_back_to_back();
        test_cfg_err();
        test_reset_mid();
        test_full_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tw_seq_gen
`default_nettype wire

// File: doc/tw_seq_gen.md
Name: tw_seq_gen

Overview:
- Parametrised successor to the fixed-size twiddle generator in the shared-butterfly FFT.
- On a start command, streams the complete twiddle sequence for one radix-2 DIT stage of a runtime-selected FFT size N = 2^log2n.
- Output is in forward (W = e^-j2πk/N) or inverse (conjugate) mode.
- Uses a quarter-wave cosine ROM with quadrant symmetry and a stallable valid/ready output pipeline.
- Feeds the butterfly twiddle port directly.

Parameters:
- DATA_WIDTH, 16, width of each of re/im, signed two's complement.
- FRAC_BITS, 14, fractional bits (+1.0 = 2^FRAC_BITS).
- MAX_LOG2N, 13, log2 of the largest supported N. The ROM is built for N_MAX = 2^MAX_LOG2N.
- LOG2N_W, 4, width of the log2n and stage inputs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- log2n  in  LOG2N_W  FFT size select, legal range 2..MAX_LOG2N.
- stage  in  LOG2N_W  DIT stage s, legal range 0..log2n-1.
- inverse  in  1  1 = conjugate output (IFFT).
- busy  out  1  high from the cycle after start is accepted until the final beat is accepted.
- cfg_err  out  1  one-cycle pulse when start carries illegal log2n or stage.
- w_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- w  out  2*DATA_WIDTH  {re, im}, re in the upper half.
- k_out  out  MAX_LOG2N  table index (k scaled to N_MAX) of the current beat.
- w_last  out  1  marks the final beat of the stage.
- done  out  1  one-cycle pulse the cycle after the final handshake.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pipeline empty.
- Reset is honoured mid-operation; the stream aborts with no done pulse.
- FSM states:
  - IDLE: start with legal config → latch log2n/stage/inverse, j=0, go to RUN. Illegal config → cfg_err pulse, stay in IDLE.
  - RUN: issue j = 0..N/2-1, one per enabled cycle. After issuing j = N/2-1, go to DRAIN.
  - DRAIN: wait until the beat tagged last is handshaken, then go to IDLE, pulse done, drop busy.
- start while busy is ignored.
- Index generation: k = (j mod 2^s) << (log2n-1-s); k_out = k << (MAX_LOG2N-log2n).
- Pipeline: 3 registered stages (index → ROM read → sign/swap output).
  - Global enable en = !w_valid | out_ready. All stages, including j, advance only when en is high.
  - With out_ready held high, the first w_valid rises 3 cycles after the start edge.
  - Throughput is 1 beat/cycle.
- Stall: while w_valid & !out_ready, w, k_out and w_last hold stable; no beat is dropped or duplicated.
- ROM: C[a] = round(cos(2πa/N_MAX)·2^FRAC_BITS) for a = 0..N_MAX/4 (N_MAX/4+1 entries), read on two ports.
- Symmetry: q = k_out[MAX_LOG2N-1:MAX_LOG2N-2], r = the remaining bits, Q = N_MAX/4.
  - q=0: (C[r], -C[Q-r])
  - q=1: (-C[Q-r], -C[r])
  - q=2: (-C[r], C[Q-r])
  - q=3: (C[Q-r], C[r])
- inverse=1 negates im after the symmetry mapping.
- Negation of representable values cannot overflow because |C| ≤ 2^FRAC_BITS < 2^(DATA_WIDTH-1); an elaboration check enforces FRAC_BITS ≤ DATA_WIDTH-2.
- w_last is high only on the beat with j = N/2-1.
- Smallest stream: log2n=2 gives 2 beats.

Decomposition:
- Package tw_pkg: N_MAX, QTR = N_MAX/4, ROM address width, FSM state enum {IDLE, RUN, DRAIN}, and a function computing the ROM constant.
- One sub-module, tw_quarter_rom: dual-read-port synchronous ROM, one-cycle read latency, contents generated at elaboration.

Test Plan:
- Defaults, log2n=3, stage=2, inverse=0, ready=1 → 4 beats k_out=0,1024,2048,3072, w = (16384,0), (11585,-11585), (0,-16384), (-11585,-11585); w_last on the 4th beat; done the next cycle.
- Same command with inverse=1 → im values 0, 11585, 16384, 11585; re values unchanged.
- log2n=3, stage=0 → 4 beats all (16384,0). log2n=13, stage=12 → 4096 beats, full CSV sweep matching reference cos/sin within ±1 LSB.
- log2n=3, stage=2 with out_ready toggling 1,0,0,1,0,1... → identical 4-beat sequence, outputs stable during stalls, exactly one done.
- start with log2n=1, then stage=log2n → cfg_err pulses, busy stays 0, no w_valid. start while busy → ignored.
- Assert rst after the 2nd beat → all outputs 0 immediately. A new start after release produces a clean full sequence.
